// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the front-panel LED controller: mode encodings,
// LED / Johnson widths and the Johnson (twisted-ring) step function.
package led_ctrl_pkg;

  localparam int unsigned LED_W     = 4;
  localparam int unsigned JOHNSON_W = 6;

  typedef enum logic [1:0] {
    MODE_SCROLL = 2'd0,
    MODE_PAUSE  = 2'd1,
    MODE_MANUAL = 2'd2
  } mode_e;

  // Shift left, feeding back the inverted MSB: 12-state twisted ring.
  function automatic logic [JOHNSON_W-1:0] johnson_next(input logic [JOHNSON_W-1:0] j);
    return {j[JOHNSON_W-2:0], ~j[JOHNSON_W-1]};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and
// rising-edge press pulse.
//   clk_i   : board clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw button level (asynchronous to clk_i)
//   pulse_o : one-clock pulse when the accepted level goes 0 -> 1
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 33000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (sync_q[1] != acc_q) begin
        // The DEBOUNCE_CYCLES-th consecutive differing sample is accepted.
        if (cnt_q == CNT_LAST) begin
          acc_q   <= sync_q[1];
          cnt_q   <= '0;
          pulse_q <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/led_mode_controller.sv
// Front-panel LED controller: debounces two buttons and runs the
// SCROLL / PAUSE / MANUAL mode machine driving four LEDs.
//   CLK      : board clock
//   RST_N    : asynchronous active-low reset
//   BTN_MODE : raw mode button, advances SCROLL -> PAUSE -> MANUAL -> SCROLL
//   BTN_SEL  : raw select button, toggles the cursor LED in MANUAL
//   LED      : registered LED drive, bit 0 = LD1
//   MODE     : current mode (0 SCROLL, 1 PAUSE, 2 MANUAL)
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV_W      = 19,
  parameter int unsigned DEBOUNCE_CYCLES = 33000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN_MODE,
  input  logic             BTN_SEL,
  output logic [LED_W-1:0] LED,
  output logic [1:0]       MODE
);

  logic mode_pulse;
  logic sel_pulse;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .btn_i   (BTN_MODE),
    .pulse_o (mode_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .btn_i   (BTN_SEL),
    .pulse_o (sel_pulse)
  );

  mode_e                 mode_q;
  logic [TICK_DIV_W-1:0] div_q;
  logic [JOHNSON_W-1:0]  j_q;
  logic [LED_W-1:0]      m_q;
  logic [1:0]            c_q;
  logic [LED_W-1:0]      led_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= MODE_SCROLL;
      div_q  <= '0;
      j_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      led_q  <= '0;
    end else begin
      // LED reflects the state held before this edge, so it lags by one clock.
      led_q <= (mode_q == MODE_MANUAL) ? m_q : j_q[LED_W-1:0];
      unique case (mode_q)
        MODE_SCROLL: begin
          div_q <= div_q + TICK_DIV_W'(1);
          if (div_q == '1) begin
            j_q <= johnson_next(j_q);
          end
          if (mode_pulse) begin
            mode_q <= MODE_PAUSE;
          end
        end
        MODE_PAUSE: begin
          if (mode_pulse) begin
            mode_q <= MODE_MANUAL;
            m_q    <= j_q[LED_W-1:0];
            c_q    <= '0;
          end
        end
        MODE_MANUAL: begin
          // Mode pulse has priority; a coincident select pulse is dropped.
          if (mode_pulse) begin
            mode_q <= MODE_SCROLL;
            j_q    <= '0;
            div_q  <= '0;
          end else if (sel_pulse) begin
            m_q[c_q] <= ~m_q[c_q];
            c_q      <= c_q + 2'd1;
          end
        end
        default: begin
          mode_q <= MODE_SCROLL;
        end
      endcase
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
module tb_led_mode_controller;

  localparam int DC    = 4;
  localparam int DIV_W = 3;
  localparam int HMAX  = 8192;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_MODE = 1'b0;
  logic       BTN_SEL = 1'b0;
  logic [3:0] LED;
  logic [1:0] MODE;

  led_mode_controller #(
    .TICK_DIV_W      (DIV_W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN_MODE (BTN_MODE),
    .BTN_SEL  (BTN_SEL),
    .LED      (LED),
    .MODE     (MODE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (button 0 = MODE, button 1 = SEL)
  bit         hist [2][HMAX];
  bit         acc [2];
  int         last_flip [2];
  bit         pend [2];
  int         edge_n;
  int         mode_m;
  int         scyc;
  int         ticks;
  logic [3:0] man;
  int         cur;
  logic [3:0] led_exp;
  logic [1:0] mode_exp;
  logic [3:0] pat [12];

  function automatic bit hget(int b, int i);
    if (i < 1) return 1'b0;
    return hist[b][i];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      acc[b] = 1'b0;
      last_flip[b] = -1000;
      pend[b] = 1'b0;
    end
    edge_n = 0; mode_m = 0; scyc = 0; ticks = 0;
    man = 4'h0; cur = 0; led_exp = 4'h0; mode_exp = 2'd0;
  endtask

  // One rising clock edge of the specified behaviour.
  task automatic model_edge(input bit m, input bit s);
    bit mp, sp, ok;
    edge_n++;
    if (edge_n >= HMAX) edge_n = HMAX - 1;
    hist[0][edge_n] = m;
    hist[1][edge_n] = s;
    mp = pend[0];
    sp = pend[1];
    // A level is accepted once the synchronised input (2 clocks late) has
    // differed from it for DC consecutive clocks since the previous change.
    for (int b = 0; b < 2; b++) begin
      ok = (edge_n - last_flip[b] >= DC);
      for (int k = 0; k < DC; k++)
        if (hget(b, edge_n - 2 - k) == acc[b]) ok = 1'b0;
      pend[b] = 1'b0;
      if (ok) begin
        acc[b] = ~acc[b];
        last_flip[b] = edge_n;
        pend[b] = acc[b];
      end
    end
    led_exp = (mode_m == 2) ? man : pat[ticks % 12];
    case (mode_m)
      0: begin
        if (scyc % (1 << DIV_W) == (1 << DIV_W) - 1) ticks++;
        scyc++;
        if (mp) mode_m = 1;
      end
      1: if (mp) begin
        mode_m = 2; man = pat[ticks % 12]; cur = 0;
      end
      default: begin
        if (mp) begin
          mode_m = 0; ticks = 0; scyc = 0;
        end else if (sp) begin
          man[cur] = ~man[cur];
          cur = (cur + 1) % 4;
        end
      end
    endcase
    mode_exp = 2'(mode_m);
  endtask

  task automatic check_outputs();
    n_checks++;
    assert (LED === led_exp) n_pass++;
    else $error("FAIL led: observed %h expected %h (edge %0d)", LED, led_exp, edge_n);
    n_checks++;
    assert (MODE === mode_exp) n_pass++;
    else $error("FAIL mode: observed %0d expected %0d (edge %0d)", MODE, mode_exp, edge_n);
  endtask

  task automatic cyc(input bit m, input bit s);
    BTN_MODE = m;
    BTN_SEL  = s;
    @(posedge CLK);
    model_edge(m, s);
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic press(input bit m, input bit s, input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc(m, s);
    for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    assert (LED === 4'h0) n_pass++;
    else $error("FAIL %s_led: observed %h expected 0", tag, LED);
    n_checks++;
    assert (MODE === 2'd0) n_pass++;
    else $error("FAIL %s_mode: observed %0d expected 0", tag, MODE);
  endtask

  initial begin
    int  hm, hs;
    bit  lm, ls, found;

    pat = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    model_reset();
    repeat (3) @(negedge CLK);
    check_outputs();
    RST_N = 1'b1;

    // Free-running scroll
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0);

    // Bouncing mode press, then held
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    press(1'b1, 1'b0, 10, 10);

    // To MANUAL, then back to SCROLL
    press(1'b1, 1'b0, 8, 8);
    press(1'b1, 1'b0, 8, 8);

    // To MANUAL and five select presses (cursor wraps)
    press(1'b1, 1'b0, 8, 8);
    press(1'b1, 1'b0, 8, 8);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 7, 7);

    // Mode and select on the same clock in MANUAL
    press(1'b1, 1'b1, 8, 8);

    // Reset while scrolling at LED = 7 with select mid-debounce
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      cyc(1'b0, 1'b0);
      if (led_exp == 4'h7 && LED == 4'h7) found = 1'b1;
    end
    n_checks++;
    assert (found) n_pass++;
    else $error("FAIL reach_led7: observed LED %h expected 7 within budget", LED);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    async_reset_check("rst_mid");
    BTN_SEL = 1'b0;
    @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0);

    // Randomised button activity
    hm = 0; hs = 0; lm = 1'b0; ls = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (hm == 0) begin
        lm = ($urandom_range(0, 3) == 0);
        hm = $urandom_range(1, 12);
      end
      if (hs == 0) begin
        ls = ($urandom_range(0, 1) == 0);
        hs = $urandom_range(1, 9);
      end
      hm--; hs--;
      cyc(lm, ls);
    end

    // Reset with mode button already held: one press after release
    cyc(1'b1, 1'b0);
    async_reset_check("rst_held");
    @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
    press(1'b1, 1'b0, 15, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
